// File: rtl/multi_cycle_datapath.sv
//==============================================================================
// Module   : multi_cycle_datapath
// Purpose  : Multi-cycle RV32I-subset core datapath with a unified valid/ready
//            memory port shared by instruction fetch and data accesses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module multi_cycle_datapath #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            memReq,
    output logic [XLEN-1:0] memAddr,
    output logic            memWrite,
    output logic [XLEN-1:0] memWriteData,
    input  logic            memReady,
    input  logic [XLEN-1:0] memReadData,
    output logic [XLEN-1:0] PC,
    output logic            instrRetired,
    output logic            halt
);

    localparam logic [2:0] c_FETCH     = 3'd0;
    localparam logic [2:0] c_DECODE    = 3'd1;
    localparam logic [2:0] c_EXECUTE   = 3'd2;
    localparam logic [2:0] c_MEM       = 3'd3;
    localparam logic [2:0] c_WRITEBACK = 3'd4;
    localparam logic [2:0] c_HALT      = 3'd5;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_IALU = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_STORE= 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_oldPc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_aluOut;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_regs [32];
    logic            r_memReq;
    logic [XLEN-1:0] r_memAddr;
    logic            r_memWrite;
    logic [XLEN-1:0] r_memWriteData;
    logic            r_retire;
    logic            r_halt;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_aluF3;
    logic            w_isR;
    logic            w_isIAlu;
    logic            w_isLw;
    logic            w_isSw;
    logic            w_isBeq;
    logic            w_isJal;
    logic            w_legal;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1Val;
    logic [XLEN-1:0] w_rs2Val;
    logic [XLEN-1:0] w_aluB;
    logic [XLEN-1:0] w_aluResult;
    logic [XLEN-1:0] w_addrSum;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_storeDone;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];

    assign w_aluF3  = (w_funct3 == 3'b000) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
    assign w_isR    = (w_opcode == c_OP_R) &&
                      (((w_funct7 == 7'b0000000) && w_aluF3) ||
                       ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));
    assign w_isIAlu = (w_opcode == c_OP_IALU) && w_aluF3;
    assign w_isLw   = (w_opcode == c_OP_LOAD)  && (w_funct3 == 3'b010);
    assign w_isSw   = (w_opcode == c_OP_STORE) && (w_funct3 == 3'b010);
    assign w_isBeq  = (w_opcode == c_OP_BR)    && (w_funct3 == 3'b000);
    assign w_isJal  = (w_opcode == c_OP_JAL);
    assign w_legal  = w_isR || w_isIAlu || w_isLw || w_isSw || w_isBeq || w_isJal;

    always_comb begin
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        if (w_isSw) begin
            w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        end else if (w_isBeq) begin
            w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        end else if (w_isJal) begin
            w_imm = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        end
    end

    assign w_rs1Val     = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2Val     = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_aluB       = w_isR ? r_b : w_imm;
    assign w_addrSum    = r_a + w_imm;
    assign w_target     = r_oldPc + w_imm;
    assign w_misaligned = (w_target[1:0] != 2'b00);

    always_comb begin
        w_aluResult = '0;
        case (w_funct3)
            3'b000:  w_aluResult = (w_isR && r_ir[30]) ? (r_a - w_aluB) : (r_a + w_aluB);
            3'b010:  w_aluResult = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_aluB))};
            3'b110:  w_aluResult = r_a | w_aluB;
            3'b111:  w_aluResult = r_a & w_aluB;
            default: w_aluResult = '0;
        endcase
    end

    // A store completes in the MEM cycle the memory accepts it, which cannot be
    // known a cycle ahead, so its retire pulse is taken straight from the handshake.
    assign w_storeDone = (r_state == c_MEM) && r_memReq && r_memWrite && memReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_FETCH;
            r_pc           <= RESET_PC;
            r_oldPc        <= '0;
            r_ir           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_aluOut       <= '0;
            r_mdr          <= '0;
            r_memReq       <= 1'b0;
            r_memAddr      <= '0;
            r_memWrite     <= 1'b0;
            r_memWriteData <= '0;
            r_retire       <= 1'b0;
            r_halt         <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                c_FETCH: begin
                    if (!r_memReq) begin
                        r_memReq  <= 1'b1;
                        r_memAddr <= r_pc;
                    end else if (memReady) begin
                        r_ir     <= memReadData[31:0];
                        r_oldPc  <= r_pc;
                        r_pc     <= r_pc + c_PC_STEP;
                        r_memReq <= 1'b0;
                        r_state  <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    r_a <= w_rs1Val;
                    r_b <= w_rs2Val;
                    if (!w_legal) begin
                        r_halt  <= 1'b1;
                        r_state <= c_HALT;
                    end else begin
                        r_state <= c_EXECUTE;
                        // beq retires in EXECUTE unless it is about to halt on a bad target
                        if (w_isBeq && !((w_rs1Val == w_rs2Val) && w_misaligned)) begin
                            r_retire <= 1'b1;
                        end
                    end
                end
                c_EXECUTE: begin
                    if (w_isBeq) begin
                        if ((r_a == r_b) && w_misaligned) begin
                            r_halt  <= 1'b1;
                            r_state <= c_HALT;
                        end else begin
                            r_state   <= c_FETCH;
                            r_memReq  <= 1'b1;
                            r_memAddr <= (r_a == r_b) ? w_target : r_pc;
                            if (r_a == r_b) begin
                                r_pc <= w_target;
                            end
                        end
                    end else if (w_isJal) begin
                        if (w_misaligned) begin
                            r_halt  <= 1'b1;
                            r_state <= c_HALT;
                        end else begin
                            r_aluOut <= r_oldPc + c_PC_STEP;
                            r_pc     <= w_target;
                            r_retire <= 1'b1;
                            r_state  <= c_WRITEBACK;
                        end
                    end else if (w_isLw || w_isSw) begin
                        r_aluOut       <= w_addrSum;
                        r_memReq       <= 1'b1;
                        r_memAddr      <= w_addrSum;
                        r_memWrite     <= w_isSw;
                        r_memWriteData <= w_isSw ? r_b : '0;
                        r_state        <= c_MEM;
                    end else begin
                        r_aluOut <= w_aluResult;
                        r_retire <= 1'b1;
                        r_state  <= c_WRITEBACK;
                    end
                end
                c_MEM: begin
                    if (memReady) begin
                        r_memWrite     <= 1'b0;
                        r_memWriteData <= '0;
                        if (r_memWrite) begin
                            r_memAddr <= r_pc;
                            r_state   <= c_FETCH;
                        end else begin
                            r_mdr    <= memReadData;
                            r_memReq <= 1'b0;
                            r_retire <= 1'b1;
                            r_state  <= c_WRITEBACK;
                        end
                    end
                end
                c_WRITEBACK: begin
                    if (w_rd != 5'd0) begin
                        r_regs[w_rd] <= w_isLw ? r_mdr : r_aluOut;
                    end
                    r_memReq  <= 1'b1;
                    r_memAddr <= r_pc;
                    r_state   <= c_FETCH;
                end
                c_HALT: begin
                    r_memReq <= 1'b0;
                    r_halt   <= 1'b1;
                end
                default: begin
                    r_memReq <= 1'b0;
                    r_halt   <= 1'b1;
                    r_state  <= c_HALT;
                end
            endcase
        end
    end

    assign memReq       = r_memReq;
    assign memAddr      = r_memAddr;
    assign memWrite     = r_memWrite;
    assign memWriteData = r_memWriteData;
    assign PC           = r_pc;
    assign instrRetired = r_retire | w_storeDone;
    assign halt         = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_datapath.sv
//==============================================================================
// Module   : tb_multi_cycle_datapath
// Purpose  : Self-checking bench: program table plus scoreboard of retirements,
//            with hand sequences for branches, halts and reset during a stall.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multi_cycle_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic        memReady = 1'b1;
    logic [31:0] memReadData;
    logic [31:0] PC;
    logic        instrRetired;
    logic        halt;

    multi_cycle_datapath #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .memReq(memReq), .memAddr(memAddr), .memWrite(memWrite),
        .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData),
        .PC(PC), .instrRetired(instrRetired), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          rd;
        logic [31:0] val;
        logic [31:0] pc;
        int          cycles;
        string       name;
    } vec_t;

    vec_t        vecs [15];
    vec_t        sbq [$];
    logic [31:0] progMem [64];
    logic [31:0] dataMem [32];
    int          nCompared = 0;
    int          nFail = 0;

    // memory model / protocol monitor state
    int          dataStall = 0;
    logic        fetchStall = 1'b0;
    int          waitCnt = 0;
    logic        rstSeen = 1'b1;
    logic        prevStalled = 1'b0;
    logic [31:0] pAddr = '0;
    logic [31:0] pData = '0;
    logic        pWrite = 1'b0;
    logic        holdBad = 1'b0;
    logic        idleBad = 1'b0;
    int          storeRun = 0;
    int          storeMaxRun = 0;
    logic [31:0] lastStoreAddr = '0;
    logic [31:0] lastStoreData = '0;

    assign memReadData = (memAddr < 32'h100) ? dataMem[memAddr[6:2]] : progMem[memAddr[7:2]];

    always @(posedge clk) rstSeen = rst;

    always @(negedge clk) begin
        if (prevStalled && !rstSeen &&
            (memReq !== 1'b1 || memAddr !== pAddr || memWrite !== pWrite || memWriteData !== pData))
            holdBad = 1'b1;
        if (memReq === 1'b0 && (memWrite !== 1'b0 || memWriteData !== 32'h0))
            idleBad = 1'b1;
        if (memReq === 1'b1 && memWrite === 1'b1) begin
            if (storeRun > 0 && memAddr == lastStoreAddr && memWriteData == lastStoreData)
                storeRun++;
            else
                storeRun = 1;
            lastStoreAddr = memAddr;
            lastStoreData = memWriteData;
            if (storeRun > storeMaxRun) storeMaxRun = storeRun;
        end else begin
            storeRun = 0;
        end
        if (memReq === 1'b1 && ((memAddr < 32'h100 && waitCnt < dataStall) ||
                                (memAddr >= 32'h100 && fetchStall))) begin
            memReady = 1'b0;
            waitCnt++;
        end else begin
            memReady = 1'b1;
            if (memReq !== 1'b1 || memAddr >= 32'h100) waitCnt = 0;
        end
        if (memReq === 1'b1 && memReady && memWrite === 1'b1)
            dataMem[memAddr[6:2]] = memWriteData;
        prevStalled = (memReq === 1'b1) && !memReady;
        pAddr  = memAddr;
        pData  = memWriteData;
        pWrite = memWrite;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic waitRetire(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            cyc++;
            if (instrRetired === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        nCompared++;
        nFail++;
        $display("FAIL retire timeout: got no retire in %0d cycles, expected one", cyc);
    endtask

    task automatic waitHalt(output int cyc, output int retires);
        cyc = 0;
        retires = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            cyc++;
            if (halt === 1'b1) return;
            if (instrRetired === 1'b1) retires++;
        end
        nCompared++;
        nFail++;
        $display("FAIL halt timeout: got halt=%b after %0d cycles, expected 1", halt, cyc);
    endtask

    task automatic runExpected();
        int   cyc;
        bit   ok;
        vec_t e;
        while (sbq.size() > 0) begin
            waitRetire(cyc, ok);
            if (!ok) begin
                sbq.delete();
                return;
            end
            e = sbq.pop_front();
            if (e.cycles != 0) check({e.name, " cycles"}, cyc, e.cycles);
            @(posedge clk);
            #1;
            check({e.name, " pc"}, PC, e.pc);
            if (e.rd >= 0) check({e.name, " rd"}, dut.r_regs[e.rd], e.val);
        end
    endtask

    function automatic vec_t mk(logic [31:0] instr, int rd, logic [31:0] val,
                                logic [31:0] pc, int cycles, string name);
        vec_t v;
        v.instr = instr; v.rd = rd; v.val = val; v.pc = pc; v.cycles = cycles; v.name = name;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          retires;
        logic        sawReq;
        logic [31:0] orAll;

        vecs[0]  = mk(32'hFFF00093,  1, 32'hFFFFFFFF, 32'h104, 0, "addi x1");
        vecs[1]  = mk(32'h00108133,  2, 32'hFFFFFFFE, 32'h108, 4, "add x2");
        vecs[2]  = mk(32'h0000A1B3,  3, 32'h00000001, 32'h10C, 4, "slt x3");
        vecs[3]  = mk(32'h00202423, -1, 32'h0,        32'h110, 7, "sw x2");
        vecs[4]  = mk(32'h00802203,  4, 32'hFFFFFFFE, 32'h114, 8, "lw x4");
        vecs[5]  = mk(32'h40100333,  6, 32'h00000001, 32'h118, 4, "sub x6");
        vecs[6]  = mk(32'h5A506393,  7, 32'h000005A5, 32'h11C, 4, "ori x7");
        vecs[7]  = mk(32'h0F03F413,  8, 32'h000000A0, 32'h120, 4, "andi x8");
        vecs[8]  = mk(32'h0063E4B3,  9, 32'h000005A5, 32'h124, 4, "or x9");
        vecs[9]  = mk(32'h00717533, 10, 32'h000005A4, 32'h128, 4, "and x10");
        vecs[10] = mk(32'h0000A593, 11, 32'h00000001, 32'h12C, 4, "slti x11");
        vecs[11] = mk(32'hFFF3A613, 12, 32'h00000000, 32'h130, 4, "slti x12");
        vecs[12] = mk(32'h00508013,  0, 32'h00000000, 32'h134, 4, "addi x0");
        vecs[13] = mk(32'h006086B3, 13, 32'h00000000, 32'h138, 4, "add x13 wrap");
        vecs[14] = mk(32'h00208463, -1, 32'h0,        32'h13C, 3, "beq not taken");

        // Straight-line program with stalled data accesses
        rst = 1'b1;
        dataStall = 3;
        for (int i = 0; i < 64; i++) progMem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dataMem[i] = 32'h0;
        for (int i = 0; i < 15; i++) begin
            progMem[i] = vecs[i].instr;
            sbq.push_back(vecs[i]);
        end
        repeat (3) step();
        check("reset memReq", {31'b0, memReq}, 32'h0);
        check("reset memWrite", {31'b0, memWrite}, 32'h0);
        check("reset halt", {31'b0, halt}, 32'h0);
        check("reset retire", {31'b0, instrRetired}, 32'h0);
        check("reset pc", PC, 32'h100);
        rst = 1'b0;
        step();
        check("first memReq", {31'b0, memReq}, 32'h1);
        check("first memAddr", memAddr, 32'h100);
        runExpected();
        check("store addr", lastStoreAddr, 32'h8);
        check("store data", lastStoreData, 32'hFFFFFFFE);
        check("store held cycles", storeMaxRun, 32'd4);

        // jal / jal backward / taken beq
        rst = 1'b1;
        for (int i = 0; i < 64; i++) progMem[i] = 32'h0;
        progMem[0] = 32'h00C002EF;
        progMem[3] = 32'hFFDFF36F;
        progMem[2] = 32'hFE000CE3;
        sbq.push_back(mk(32'h00C002EF,  5, 32'h104, 32'h10C, 0, "jal x5"));
        sbq.push_back(mk(32'hFFDFF36F,  6, 32'h110, 32'h108, 4, "jal x6 back"));
        sbq.push_back(mk(32'hFE000CE3, -1, 32'h0,   32'h100, 3, "beq taken"));
        repeat (2) step();
        rst = 1'b0;
        step();
        runExpected();
        check("beq refetch req", {31'b0, memReq}, 32'h1);
        check("beq refetch addr", memAddr, 32'h100);

        // illegal instruction halts; reset recovers
        rst = 1'b1;
        for (int i = 0; i < 64; i++) progMem[i] = 32'h0;
        repeat (2) step();
        rst = 1'b0;
        waitHalt(cyc, retires);
        check("illegal halt latency", cyc, 32'd3);
        sawReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (memReq !== 1'b0 || instrRetired !== 1'b0) sawReq = 1'b1;
        end
        check("halt quiet", {31'b0, sawReq}, 32'h0);
        check("halt held", {31'b0, halt}, 32'h1);
        check("halt pc", PC, 32'h104);
        rst = 1'b1;
        progMem[0] = 32'h00700093;
        progMem[1] = 32'h002003EF;
        repeat (2) step();
        check("halt cleared by rst", {31'b0, halt}, 32'h0);
        rst = 1'b0;
        step();
        check("restart addr", memAddr, 32'h100);
        sbq.push_back(mk(32'h00700093, 1, 32'h7, 32'h104, 0, "addi x1 after halt"));
        runExpected();

        // misaligned jal target halts without retiring or moving PC
        waitHalt(cyc, retires);
        check("misaligned jal retires", retires, 32'd0);
        check("misaligned jal pc", PC, 32'h108);
        check("misaligned jal rd", dut.r_regs[7], 32'h0);

        // reset while a fetch is stalled
        rst = 1'b1;
        fetchStall = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("stalled fetch req", {31'b0, memReq}, 32'h1);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("abandon memReq", {31'b0, memReq}, 32'h0);
        check("abandon pc", PC, 32'h100);
        check("abandon retire", {31'b0, instrRetired}, 32'h0);
        orAll = '0;
        for (int i = 0; i < 32; i++) orAll |= dut.r_regs[i];
        check("abandon gprs", orAll, 32'h0);
        fetchStall = 1'b0;
        rst = 1'b0;
        repeat (2) step();

        check("hold while stalled", {31'b0, holdBad}, 32'h0);
        check("idle write lines", {31'b0, idleBad}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule

`default_nettype wire
